fetch_pc_gen: RTL and testbench

// Next-fetch-PC generator sitting directly upstream of the bimodal predictor: drives FETCH_PC and consumes
// the predictor's decode-stage outputs (PREDICT, PREDICTOR_TNT, PREDICTOR_BRANCH_TARGET) and execute-stage

---
 rtl/fetch_pc_gen.sv | 99 +++++++++
 tb/tb_fetch_pc_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Next-fetch-PC generator: sequential, predicted-taken and mispredict
// recovery selection, squash/flush pulses and branch perf counters.
module fetch_pc_gen #(
   parameter int unsigned ADDR_W = 40,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_fetch,
   input  logic              if_branch_dec,
   input  logic [ADDR_W-1:0] dec_pc,
   input  logic              predict,
   input  logic [1:0]        predictor_tnt,
   input  logic [ADDR_W-1:0] predictor_target,
   input  logic              if_branch_ex,
   input  logic              predictor_hit,
   input  logic [ADDR_W-1:0] exe_branch_result,
   output logic [ADDR_W-1:0] fetch_pc,
   output logic              fetch_valid,
   output logic              dec_squash,
   output logic              exe_flush,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  mispredict_cnt
);

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RUN     = 2'd1,
      RECOVER = 2'd2
   } state_t;

   state_t            state;
   logic              pend_vld;
   logic [ADDR_W-1:0] pend_pc;
   logic              mispredict;
   logic              dec_taken;

   // dec_pc is carried for debug visibility only; the target comes from the predictor
   logic unused_dec_pc;
   assign unused_dec_pc = ^dec_pc;

   assign mispredict = if_branch_ex & ~predictor_hit;
   assign dec_taken  = if_branch_dec & predict & predictor_tnt[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= BOOT;
         fetch_pc       <= RESET_PC;
         fetch_valid    <= 1'b0;
         dec_squash     <= 1'b0;
         exe_flush      <= 1'b0;
         pend_vld       <= 1'b0;
         pend_pc        <= '0;
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else begin
         dec_squash <= 1'b0;
         exe_flush  <= 1'b0;

         if (if_branch_ex && branch_cnt != '1)
            branch_cnt <= branch_cnt + 1'b1;
         if (mispredict && mispredict_cnt != '1)
            mispredict_cnt <= mispredict_cnt + 1'b1;

         if (state == BOOT) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
         end else if (mispredict) begin
            exe_flush <= 1'b1;
            if (stall_fetch) begin
               // youngest resolved branch wins while waiting on the stall
               pend_vld    <= 1'b1;
               pend_pc     <= exe_branch_result;
               fetch_valid <= 1'b0;
            end else begin
               pend_vld    <= 1'b0;
               fetch_pc    <= exe_branch_result;
               fetch_valid <= 1'b1;
               state       <= RECOVER;
            end
         end else if (stall_fetch) begin
            fetch_valid <= fetch_valid;
         end else if (pend_vld) begin
            pend_vld    <= 1'b0;
            fetch_pc    <= pend_pc;
            fetch_valid <= 1'b1;
            state       <= RECOVER;
         end else if (state == RUN && dec_taken) begin
            fetch_pc   <= predictor_target;
            dec_squash <= 1'b1;
         end else begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
            state    <= RUN;
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: driver queues expected outputs,
// monitor pops and compares one entry per cycle.
module tb_fetch_pc_gen;

   localparam int AW = 40;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall_fetch;
   logic          if_branch_dec;
   logic [AW-1:0] dec_pc;
   logic          predict;
   logic [1:0]    predictor_tnt;
   logic [AW-1:0] predictor_target;
   logic          if_branch_ex;
   logic          predictor_hit;
   logic [AW-1:0] exe_branch_result;
   logic [AW-1:0] fetch_pc;
   logic          fetch_valid;
   logic          dec_squash;
   logic          exe_flush;
   logic [CW-1:0] branch_cnt;
   logic [CW-1:0] mispredict_cnt;

   typedef struct {
      logic [AW-1:0] pc;
      logic          fv;
      logic          sq;
      logic          fl;
      logic [CW-1:0] bc;
      logic [CW-1:0] mc;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   logic [CW-1:0] eb = '0;
   logic [CW-1:0] em = '0;

   fetch_pc_gen #(.ADDR_W(AW), .RESET_PC('0), .CNT_W(CW)) dut (
      .clk(clk),
      .rst(rst),
      .stall_fetch(stall_fetch),
      .if_branch_dec(if_branch_dec),
      .dec_pc(dec_pc),
      .predict(predict),
      .predictor_tnt(predictor_tnt),
      .predictor_target(predictor_target),
      .if_branch_ex(if_branch_ex),
      .predictor_hit(predictor_hit),
      .exe_branch_result(exe_branch_result),
      .fetch_pc(fetch_pc),
      .fetch_valid(fetch_valid),
      .dec_squash(dec_squash),
      .exe_flush(exe_flush),
      .branch_cnt(branch_cnt),
      .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("fetch_pc", 64'(fetch_pc), 64'(e.pc));
         chk("fetch_valid", 64'(fetch_valid), 64'(e.fv));
         chk("dec_squash", 64'(dec_squash), 64'(e.sq));
         chk("exe_flush", 64'(exe_flush), 64'(e.fl));
         chk("branch_cnt", 64'(branch_cnt), 64'(e.bc));
         chk("mispredict_cnt", 64'(mispredict_cnt), 64'(e.mc));
      end
   end

   task automatic step(
      input logic st, bd, pr, input logic [1:0] tn, input logic [AW-1:0] tg,
      input logic bx, ht, input logic [AW-1:0] rs,
      input logic [AW-1:0] epc, input logic efv, esq, efl);
      exp_t e;
      stall_fetch       = st;
      if_branch_dec     = bd;
      dec_pc            = bd ? AW'('h100) : '0;
      predict           = pr;
      predictor_tnt     = tn;
      predictor_target  = tg;
      if_branch_ex      = bx;
      predictor_hit     = ht;
      exe_branch_result = rs;
      if (!rst) begin
         eb = '0;
         em = '0;
      end else if (bx) begin
         if (eb != '1) eb = eb + 1'b1;
         if (!ht && em != '1) em = em + 1'b1;
      end
      e.pc = epc; e.fv = efv; e.sq = esq; e.fl = efl;
      e.bc = eb; e.mc = em;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input logic [AW-1:0] epc, input logic efv);
      step(0, 0, 0, 2'b00, '0, 0, 0, '0, epc, efv, 0, 0);
   endtask

   task automatic stl(input logic [AW-1:0] epc, input logic efv);
      step(1, 0, 0, 2'b00, '0, 0, 0, '0, epc, efv, 0, 0);
   endtask

   initial begin
      rst = 1'b0;
      // reset and boot
      idle('0, 0);
      idle('0, 0);
      rst = 1'b1;
      idle('0, 1);
      idle(40'h4, 1);
      idle(40'h8, 1);
      idle(40'hC, 1);
      // decode taken, then weakly-not-taken counter
      step(0, 1, 1, 2'b11, 40'h400, 0, 0, '0, 40'h400, 1, 1, 0);
      idle(40'h404, 1);
      step(0, 1, 1, 2'b01, 40'h400, 0, 0, '0, 40'h408, 1, 0, 0);
      // mispredict beats decode taken; RECOVER ignores decode
      step(0, 1, 1, 2'b11, 40'h400, 1, 0, 40'h800, 40'h800, 1, 0, 1);
      step(0, 1, 1, 2'b11, 40'h400, 0, 0, '0, 40'h804, 1, 0, 0);
      step(0, 1, 1, 2'b11, 40'h400, 0, 0, '0, 40'h400, 1, 1, 0);
      idle(40'h404, 1);
      step(0, 0, 0, 2'b00, '0, 1, 1, 40'h999, 40'h408, 1, 0, 0);
      // mispredict under stall
      step(1, 0, 0, 2'b00, '0, 1, 0, 40'h900, 40'h408, 0, 0, 1);
      step(1, 1, 1, 2'b11, 40'h400, 0, 0, '0, 40'h408, 0, 0, 0);
      stl(40'h408, 0);
      idle(40'h900, 1);
      idle(40'h904, 1);
      stl(40'h904, 1);
      // pending overwritten by younger mispredict
      step(1, 0, 0, 2'b00, '0, 1, 0, 40'hA00, 40'h904, 0, 0, 1);
      step(1, 0, 0, 2'b00, '0, 1, 0, 40'hB00, 40'h904, 0, 0, 1);
      idle(40'hB00, 1);
      idle(40'hB04, 1);
      // PC wrap and counter saturation
      step(0, 0, 0, 2'b00, '0, 1, 0, 40'hFFFFFFFFFC,
           40'hFFFFFFFFFC, 1, 0, 1);
      idle('0, 1);
      for (int i = 0; i < 20; i++)
         step(0, 0, 0, 2'b00, '0, 1, 0, 40'h1000, 40'h1000, 1, 0, 1);
      idle(40'h1004, 1);
      // reset during RECOVER with a stalled mispredict pending
      step(0, 0, 0, 2'b00, '0, 1, 0, 40'h2000, 40'h2000, 1, 0, 1);
      rst = 1'b0;
      step(1, 0, 0, 2'b00, '0, 1, 0, 40'h3000, '0, 0, 0, 0);
      rst = 1'b1;
      idle('0, 1);
      idle(40'h4, 1);
      idle(40'h8, 1);
      repeat (2) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain: got %0d left want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
